// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   state_t : fetch FSM states
//   OP_HLT  : opcode of the halt instruction, located at instr[OP_MSB:OP_LSB]
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [3:0]  OP_HLT = 4'hF;
  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;

  // True when the opcode field decodes as a halt.
  function automatic logic is_hlt(input logic [3:0] opcode);
    return opcode == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between the fetch queue, instruction memory, branch unit and IF/ID.
//   master : fetch_queue side (drives imem request and the instruction stream)
//   slave  : environment side (memory data, redirect, IF/ID ready)
interface fetch_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 4
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic               imem_rd;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic               instr_vld;
  logic               instr_rdy;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  pc_out;
  logic [ADDR_W-1:0]  pc_plus_out;
  logic [CNT_W-1:0]   q_count;
  logic               hlt;

  modport master (
    output imem_rd, imem_addr, instr_vld, instr_out, pc_out, pc_plus_out, q_count, hlt,
    input  imem_data, br_taken, br_target, instr_rdy
  );

  modport slave (
    input  imem_rd, imem_addr, instr_vld, instr_out, pc_out, pc_plus_out, q_count, hlt,
    output imem_data, br_taken, br_target, instr_rdy
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for {instruction, pc} entries; head is visible combinationally.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write an entry
//   pop      : drop the head entry
//   clr      : empty the FIFO (wins over push/pop)
//   head     : oldest entry, count : occupancy
module fetch_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;

  assign full = (count == CNT_W'(DEPTH));
  assign head = mem[rd_ptr];

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // The fetch credit scheme must never overfill the queue.
  assert property (@(posedge clk) disable iff (rst || clr) !(push && !pop && full));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues instruction-memory reads, buffers
// returned instructions with their PCs and presents them to IF/ID by valid/ready.
// Handles branch redirect (flushes queued and in-flight fetches) and HLT drain.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_if master (imem request/data, redirect, IF/ID stream, status)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       INSTR_W  = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       PC_INC   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [ADDR_W-1:0]  tag_pc;
  logic               inflight;

  logic               issue, push, pop, clr, head_vld;
  logic [ENTRY_W-1:0] head;
  logic [INSTR_W-1:0] head_instr;
  logic [ADDR_W-1:0]  head_pc;
  logic [CNT_W-1:0]   count;

  fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clr   (clr),
    .din   ({bus.imem_data, tag_pc}),
    .head  (head),
    .count (count)
  );

  assign head_instr = head[ENTRY_W-1:ADDR_W];
  assign head_pc    = head[ADDR_W-1:0];
  assign head_vld   = (count != '0);

  // Credit: queued plus in-flight entries may never exceed DEPTH.
  assign issue = !rst && (state == FETCH) && !bus.br_taken &&
                 ((SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH));
  assign pop   = bus.instr_vld && bus.instr_rdy;

  // State, PC, and the one-deep in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      inflight <= issue;
      if (issue) tag_pc <= pc;
    end
  end

  // Next-state logic; redirect squashes the arriving return and flushes the queue.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    clr       = 1'b0;
    if (bus.br_taken && state != HALT) begin
      clr       = 1'b1;
      pc_nxt    = bus.br_target;
      state_nxt = FETCH;
    end else begin
      if (issue) pc_nxt = pc + ADDR_W'(PC_INC);
      push = inflight && (state != HALT);
      case (state)
        FETCH: if (push && is_hlt(bus.imem_data[OP_MSB:OP_LSB])) state_nxt = DRAIN;
        DRAIN: begin
          // Entries ahead of the HLT are older and cannot be HLTs, so the first HLT head is it.
          if (pop && is_hlt(head_instr[OP_MSB:OP_LSB])) begin
            state_nxt = HALT;
            clr       = 1'b1;
          end
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = FETCH;
      endcase
    end
  end

  assign bus.imem_rd     = issue;
  assign bus.imem_addr   = pc;
  assign bus.instr_vld   = head_vld && !bus.br_taken;
  assign bus.instr_out   = head_vld ? head_instr : '0;
  assign bus.pc_out      = head_vld ? head_pc : '0;
  assign bus.pc_plus_out = bus.pc_out + ADDR_W'(PC_INC);
  assign bus.q_count     = count;
  assign bus.hlt         = (state == HALT);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed latency/boundary scenarios plus
// randomized ready/redirect traffic against an expected-PC-stream scoreboard.
module tb_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.INSTR_W(16), .ADDR_W(16), .DEPTH(4)) bus  ();
  fetch_if #(.INSTR_W(16), .ADDR_W(16), .DEPTH(4)) bus2 ();

  fetch_queue #(.INSTR_W(16), .ADDR_W(16), .DEPTH(4), .PC_INC(2), .RESET_PC(16'h0000)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  fetch_queue #(.INSTR_W(16), .ADDR_W(16), .DEPTH(4), .PC_INC(2), .RESET_PC(16'hFFFE)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  // Program image: one optional HLT, every other word a non-HLT pattern.
  logic        hlt_en = 1'b0;
  logic [15:0] hlt_pc = 16'h0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (hlt_en && a == hlt_pc) return 16'hF000;
    w = a * 16'd3 + 16'h1234;
    if (w[15:12] == 4'hF) w[15:12] = 4'h7;
    return w;
  endfunction

  // Instruction memory: data valid one cycle after the request, garbage otherwise.
  always @(posedge clk) begin
    bus.imem_data  <= bus.imem_rd  ? mem_word(bus.imem_addr)  : 16'($urandom);
    bus2.imem_data <= bus2.imem_rd ? mem_word(bus2.imem_addr) : 16'($urandom);
  end

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: the PCs IF/ID must see, in order, from the current fetch start.
  logic [15:0] exp_q[$];
  logic        model_halted = 1'b0;
  logic        hlt_d        = 1'b0;

  function automatic void gen_stream(input logic [15:0] start);
    logic [15:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(a);
      if (hlt_en && a == hlt_pc) break;
      a = a + 16'd2;
    end
  endfunction

  // Monitor: compares every accepted instruction and the halt flag.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst) begin
      chk("hlt", 32'(bus.hlt), 32'(hlt_d));
      chk("q_count_bound", 32'(bus.q_count <= 3'd4), 32'd1);
      if (bus.instr_vld && bus.instr_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got pc_out=%0h expected no instruction", bus.pc_out);
        end else begin
          e = exp_q.pop_front();
          chk("pc_out", 32'(bus.pc_out), 32'(e));
          chk("instr_out", 32'(bus.instr_out), 32'(mem_word(e)));
          chk("pc_plus_out", 32'(bus.pc_plus_out), 32'(16'(e + 16'd2)));
          pops++;
          if (hlt_en && e == hlt_pc) model_halted = 1'b1;
        end
      end
      hlt_d = model_halted;
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset with the given program/ready setup; returns at the start of cycle 0.
  task automatic do_reset(input logic he, input logic [15:0] hp, input logic rdy);
    rst            = 1'b1;
    hlt_en         = he;
    hlt_pc         = hp;
    bus.br_taken   = 1'b0;
    bus.br_target  = 16'h0;
    bus.instr_rdy  = rdy;
    bus2.br_taken  = 1'b0;
    bus2.br_target = 16'h0;
    bus2.instr_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_rd", 32'(bus.imem_rd), 32'd0);
    chk("rst_instr_vld", 32'(bus.instr_vld), 32'd0);
    chk("rst_q_count", 32'(bus.q_count), 32'd0);
    chk("rst_hlt", 32'(bus.hlt), 32'd0);
    chk("rst_instr_out", 32'(bus.instr_out), 32'd0);
    chk("rst_pc_out", 32'(bus.pc_out), 32'd0);
    next_cyc();
    rst          = 1'b0;
    model_halted = 1'b0;
    hlt_d        = 1'b0;
    pops         = 0;
    gen_stream(16'h0000);
  endtask

  task automatic redirect(input logic [15:0] tgt);
    bus.br_taken  = 1'b1;
    bus.br_target = tgt;
    if (!model_halted) gen_stream(tgt);
  endtask

  initial begin
    int issues;
    int since_br;

    // Streaming fetch, plus PC wrap on the second instance.
    do_reset(1'b0, 16'h0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t1_imem_rd", 32'(bus.imem_rd), 32'd1);
      chk("t1_imem_addr", 32'(bus.imem_addr), 32'(16'(2 * c)));
      chk("t1_instr_vld", 32'(bus.instr_vld), 32'(c >= 2));
      if (c < 2) chk("t6_imem_addr", 32'(bus2.imem_addr), 32'(16'(16'hFFFE + 16'(2 * c))));
      if (c == 2) begin
        chk("t1_first_pc", 32'(bus.pc_out), 32'h0);
        chk("t1_first_pc_plus", 32'(bus.pc_plus_out), 32'h2);
        chk("t6_first_vld", 32'(bus2.instr_vld), 32'd1);
        chk("t6_first_pc", 32'(bus2.pc_out), 32'hFFFE);
        chk("t6_first_pc_plus", 32'(bus2.pc_plus_out), 32'h0);
      end
      next_cyc();
    end
    repeat (20) next_cyc();
    chk("t1_pop_count", 32'(pops), 32'd24);

    // Stall from cycle 0: credit stops issue at DEPTH, then drain resumes it.
    do_reset(1'b0, 16'h0, 1'b0);
    issues = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.imem_rd) issues++;
      next_cyc();
    end
    chk("t2_issues", 32'(issues), 32'd4);
    @(negedge clk);
    chk("t2_full_rd", 32'(bus.imem_rd), 32'd0);
    chk("t2_full_count", 32'(bus.q_count), 32'd4);
    next_cyc();
    bus.instr_rdy = 1'b1;
    @(negedge clk);
    chk("t2_release_rd", 32'(bus.imem_rd), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("t2_resume_rd", 32'(bus.imem_rd), 32'd1);
    chk("t2_resume_addr", 32'(bus.imem_addr), 32'h8);
    next_cyc();
    repeat (6) next_cyc();
    chk("t2_drain_pops", 32'(pops >= 4), 32'd1);

    // Redirect with a full queue.
    do_reset(1'b0, 16'h0, 1'b0);
    repeat (8) next_cyc();
    bus.instr_rdy = 1'b1;
    redirect(16'h0100);
    @(negedge clk);
    chk("t3_br_vld", 32'(bus.instr_vld), 32'd0);
    chk("t3_br_rd", 32'(bus.imem_rd), 32'd0);
    next_cyc();
    bus.br_taken = 1'b0;
    @(negedge clk);
    chk("t3_flush_count", 32'(bus.q_count), 32'd0);
    chk("t3_target_rd", 32'(bus.imem_rd), 32'd1);
    chk("t3_target_addr", 32'(bus.imem_addr), 32'h0100);
    next_cyc();
    @(negedge clk);
    chk("t3_b2_vld", 32'(bus.instr_vld), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("t3_b3_vld", 32'(bus.instr_vld), 32'd1);
    chk("t3_b3_pc", 32'(bus.pc_out), 32'h0100);
    next_cyc();
    repeat (5) next_cyc();

    // HLT at PC 6: drain, halt, then redirect is ignored.
    do_reset(1'b1, 16'h0006, 1'b1);
    issues = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.imem_rd) issues++;
      if (c == 5) chk("t4_hlt_c5", 32'(bus.hlt), 32'd0);
      if (c == 6) chk("t4_hlt_c6", 32'(bus.hlt), 32'd1);
      next_cyc();
    end
    chk("t4_issues", 32'(issues), 32'd5);
    chk("t4_pops", 32'(pops), 32'd4);
    chk("t4_stream_done", 32'(exp_q.size()), 32'd0);
    redirect(16'h0020);
    next_cyc();
    bus.br_taken = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t4_halt_rd", 32'(bus.imem_rd), 32'd0);
      chk("t4_halt_vld", 32'(bus.instr_vld), 32'd0);
      chk("t4_halt_sticky", 32'(bus.hlt), 32'd1);
      next_cyc();
    end

    // HLT queued, redirect before it is consumed.
    do_reset(1'b1, 16'h0006, 1'b0);
    repeat (8) next_cyc();
    bus.instr_rdy = 1'b1;
    redirect(16'h0040);
    next_cyc();
    bus.br_taken = 1'b0;
    @(negedge clk);
    chk("t5_target_rd", 32'(bus.imem_rd), 32'd1);
    chk("t5_target_addr", 32'(bus.imem_addr), 32'h0040);
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk("t5_b3_vld", 32'(bus.instr_vld), 32'd1);
    chk("t5_b3_pc", 32'(bus.pc_out), 32'h0040);
    next_cyc();
    repeat (8) next_cyc();
    chk("t5_no_halt", 32'(bus.hlt), 32'd0);
    chk("t5_progress", 32'(pops >= 5), 32'd1);

    // Randomized ready and redirects, without and with a reachable HLT.
    for (int seg = 0; seg < 2; seg++) begin
      do_reset(seg == 1, 16'h0080, 1'b1);
      since_br = 0;
      for (int c = 0; c < 400; c++) begin
        bus.instr_rdy = ($urandom % 4) != 0;
        if (($urandom % 16) == 0 || since_br >= 60) begin
          redirect({8'h00, 8'($urandom)} & 16'hFFFE);
          since_br = 0;
        end else begin
          bus.br_taken = 1'b0;
          since_br++;
        end
        next_cyc();
      end
      bus.br_taken = 1'b0;
      chk("rand_progress", 32'(pops > 0), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
